// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core
// Revision : 1.0
// ============================================================================
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [2:0] c_F3_WORD   = 3'b010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e      state_q;
  logic        illegal_q;
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  logic w_is_r;
  logic w_is_i;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jalr;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_is_jal;
  logic w_legal;

  logic [1:0] w_a_sel_op;
  logic       w_b_sel_op;

  logic w_mem_req;
  logic w_mem_we;
  logic w_ir_we;
  logic w_pc_we;
  logic w_rf_we;

  // Instruction classification from the latched IR fields
  assign w_is_r      = (opcode == c_OP_R);
  assign w_is_i      = (opcode == c_OP_I);
  assign w_is_load   = (opcode == c_OP_LOAD)  && (funct3 == c_F3_WORD);
  assign w_is_store  = (opcode == c_OP_STORE) && (funct3 == c_F3_WORD);
  assign w_is_branch = (opcode == c_OP_BRANCH) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b100) || (funct3 == 3'b110));
  assign w_is_jalr   = (opcode == c_OP_JALR);
  assign w_is_lui    = (opcode == c_OP_LUI);
  assign w_is_auipc  = (opcode == c_OP_AUIPC);
  assign w_is_jal    = (opcode == c_OP_JAL);

  assign w_legal = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch |
                   w_is_jalr | w_is_lui | w_is_auipc | w_is_jal;

  assign w_a_sel_op = w_is_lui ? 2'd2 : ((w_is_auipc | w_is_jal) ? 2'd1 : 2'd0);
  assign w_b_sel_op = ~(w_is_r | w_is_branch);

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_rf_we   = 1'b0;
    addr_sel  = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    case (state_q)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = mem_ready;
      end
      S_EXEC: begin
        alu_a_sel = w_a_sel_op;
        alu_b_sel = w_b_sel_op;
        if (w_is_branch) begin
          w_pc_we = 1'b1;
          pc_src  = br_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        addr_sel  = 1'b1;
        w_mem_we  = w_is_store;
        alu_a_sel = w_a_sel_op;
        alu_b_sel = w_b_sel_op;
        w_pc_we   = w_is_store & mem_ready;
      end
      S_WB: begin
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        wb_sel  = w_is_load ? 2'd1 : ((w_is_jal | w_is_jalr) ? 2'd2 : 2'd0);
        pc_src  = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
      end
      default: begin
      end
    endcase
  end

  // Strobes are held low for the whole time reset is asserted, not just after the edge
  assign mem_req = w_mem_req & rstn;
  assign mem_we  = w_mem_we  & rstn;
  assign ir_we   = w_ir_we   & rstn;
  assign pc_we   = w_pc_we   & rstn;
  assign rf_we   = w_rf_we   & rstn;

  assign instret_d = instret_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      if (w_pc_we) begin
        instret_q <= instret_d;
      end
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (w_legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_load | w_is_store) state_q <= S_MEM;
          else if (w_is_branch)       state_q <= S_FETCH;
          else                        state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) state_q <= w_is_store ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Randomized scoreboard bench for multicycle_ctrl
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3),
    .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .state(state),
    .instret(instret)
  );

  typedef struct {
    int         cpi;
    int         nreq;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       rf_we;
    logic       mem_we;
    logic       illegal;
    logic       is_ls;
    logic       has_wb;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nreq = 0;
  int          nir = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with no pending instruction (t=%0t)", nm, $time);
  endtask

  // Reference: per-instruction outcome taken straight from the ISA-subset rules
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic br, input int w1, input int w2);
    exp_t e;
    logic r, i, ld, st, bq, jr, lui, aui, jl;
    r   = (op == 7'b0110011);
    i   = (op == 7'b0010011);
    ld  = (op == 7'b0000011) && (f3 == 3'd2);
    st  = (op == 7'b0100011) && (f3 == 3'd2);
    bq  = (op == 7'b1100011) && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6);
    jr  = (op == 7'b1100111);
    lui = (op == 7'b0110111);
    aui = (op == 7'b0010111);
    jl  = (op == 7'b1101111);
    e.illegal = !(r | i | ld | st | bq | jr | lui | aui | jl);
    e.is_ls   = ld | st;
    e.has_wb  = !(bq | st);
    e.cpi     = (bq ? 3 : (ld ? 5 : 4)) + w1 + (e.is_ls ? w2 : 0);
    e.nreq    = 1 + w1 + (e.is_ls ? 1 + w2 : 0);
    e.a_sel   = lui ? 2'd2 : ((aui | jl) ? 2'd1 : 2'd0);
    e.b_sel   = !(r | bq);
    e.rf_we   = e.has_wb;
    e.wb_sel  = ld ? 2'd1 : ((jl | jr) ? 2'd2 : 2'd0);
    e.pc_src  = bq ? {1'b0, br} : (jl ? 2'd1 : (jr ? 2'd2 : 2'd0));
    e.mem_we  = st;
    return e;
  endfunction

  // Monitor: per-cycle port checks plus scoreboard pop on every retirement
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_strobes", {27'b0, mem_req, mem_we, ir_we, pc_we, rf_we}, 32'd0);
      q.delete();
      cyc = 0; nreq = 0; nir = 0;
      exp_cnt = 32'd0;
    end else begin
      cyc++;
      if (mem_req) nreq++;
      if (ir_we) nir++;
      case (state)
        3'd0: begin
          chk("fetch_port", {29'b0, mem_req, addr_sel, mem_we}, 32'b100);
          chk("fetch_ir_we", {31'b0, ir_we}, {31'b0, mem_ready});
        end
        3'd1: chk("decode_quiet", {19'b0, mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we,
                                   pc_src, alu_a_sel, alu_b_sel, wb_sel}, 32'd0);
        3'd2: begin
          if (q.size() == 0) fail("exec_pending");
          else begin
            chk("exec_a_sel", {30'b0, alu_a_sel}, {30'b0, q[0].a_sel});
            chk("exec_b_sel", {31'b0, alu_b_sel}, {31'b0, q[0].b_sel});
            chk("exec_mem_req", {31'b0, mem_req}, 32'd0);
          end
        end
        3'd3: begin
          if (q.size() == 0) fail("mem_pending");
          else begin
            chk("mem_port", {29'b0, mem_req, addr_sel, mem_we}, {29'b0, 2'b11, q[0].mem_we});
            chk("mem_alu_sel", {29'b0, alu_a_sel, alu_b_sel}, {29'b0, q[0].a_sel, q[0].b_sel});
          end
        end
        3'd4: chk("wb_quiet", {28'b0, mem_req, alu_a_sel, alu_b_sel}, 32'd0);
        default: begin
        end
      endcase
      if (pc_we) begin
        if (q.size() == 0) fail("retire_unexpected");
        else begin
          me = q.pop_front();
          chk("retire_cycles", cyc, me.cpi);
          chk("retire_pc_src", {30'b0, pc_src}, {30'b0, me.pc_src});
          chk("retire_rf_we", {31'b0, rf_we}, {31'b0, me.rf_we});
          chk("retire_wb_sel", {30'b0, wb_sel}, {30'b0, me.wb_sel});
          chk("retire_instret", instret, exp_cnt);
          chk("retire_mem_cycles", nreq, me.nreq);
          chk("retire_ir_we_count", nir, 1);
          exp_cnt = exp_cnt + 32'd1;
        end
        cyc = 0; nreq = 0; nir = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction through its expected phases; returns with the DUT back in FETCH
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic br,
                       input int w1, input int w2);
    exp_t e;
    e = model(op, f3, br, w1, w2);
    opcode = op; funct3 = f3; br_taken = br;
    if (!e.illegal) q.push_back(e);
    for (int k = 0; k < w1; k++) begin mem_ready = 1'b0; tick(); end
    mem_ready = 1'b1; tick();
    mem_ready = 1'($urandom_range(0, 1)); tick();
    if (!e.illegal) begin
      mem_ready = 1'($urandom_range(0, 1)); tick();
      if (e.is_ls) begin
        for (int k = 0; k < w2; k++) begin mem_ready = 1'b0; tick(); end
        mem_ready = 1'b1; tick();
      end
      if (e.has_wb) begin mem_ready = 1'($urandom_range(0, 1)); tick(); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic illegal_case(input logic [6:0] op, input logic [2:0] f3);
    issue(op, f3, 1'b0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("halt_state", {29'b0, state}, 32'd5);
      chk("halt_illegal", {31'b0, illegal}, 32'd1);
      chk("halt_strobes", {27'b0, mem_req, mem_we, ir_we, pc_we, rf_we}, 32'd0);
      mem_ready = 1'($urandom_range(0, 1));
      tick();
    end
    mem_ready = 1'b0;
    rstn = 1'b0;
    tick();
    chk("halt_rst_state", {29'b0, state}, 32'd0);
    chk("halt_rst_illegal", {31'b0, illegal}, 32'd0);
    chk("halt_rst_instret", instret, 32'd0);
    rstn = 1'b1;
  endtask

  logic [6:0] r_op;
  logic [2:0] r_f3;
  logic [2:0] br_f3 [3];

  initial begin
    br_f3[0] = 3'd0; br_f3[1] = 3'd4; br_f3[2] = 3'd6;
    rstn = 1'b0; opcode = 7'd0; funct3 = 3'd0; br_taken = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("reset_state", {29'b0, state}, 32'd0);
    chk("reset_illegal", {31'b0, illegal}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    rstn = 1'b1;

    issue(7'b0110011, 3'd0, 1'b0, 0, 0);            // ADD
    chk("add_instret", instret, 32'd1);
    issue(7'b0000011, 3'd2, 1'b0, 0, 2);            // LW, 2 wait states
    issue(7'b1100011, 3'd0, 1'b1, 0, 0);            // BEQ taken
    issue(7'b1100011, 3'd0, 1'b0, 0, 0);            // BEQ not taken
    issue(7'b1100111, 3'd0, 1'b0, 0, 0);            // JALR
    issue(7'b1101111, 3'd0, 1'b0, 2, 0);            // JAL, fetch waits
    issue(7'b0100011, 3'd2, 1'b0, 1, 1);            // SW
    chk("directed_instret", instret, 32'd7);

    for (int n = 0; n < 80; n++) begin
      r_f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 8))
        0: r_op = 7'b0110011;
        1: r_op = 7'b0010011;
        2: begin r_op = 7'b0000011; r_f3 = 3'd2; end
        3: begin r_op = 7'b0100011; r_f3 = 3'd2; end
        4: begin r_op = 7'b1100011; r_f3 = br_f3[$urandom_range(0, 2)]; end
        5: r_op = 7'b1100111;
        6: r_op = 7'b0110111;
        7: r_op = 7'b0010111;
        default: r_op = 7'b1101111;
      endcase
      issue(r_op, r_f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    chk("queue_drained", q.size(), 32'd0);
    chk("random_instret", instret, 32'd87);

    // Counter wrap: preload the top value, then retire one instruction
    dut.instret_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    issue(7'b0010011, 3'd0, 1'b0, 0, 0);
    chk("wrap_instret", instret, 32'd0);
    issue(7'b0110011, 3'd0, 1'b0, 0, 0);
    chk("post_wrap_instret", instret, 32'd1);

    // Reset while a store is stalled in MEM
    opcode = 7'b0100011; funct3 = 3'd2; br_taken = 1'b0;
    q.push_back(model(7'b0100011, 3'd2, 1'b0, 0, 5));
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick(); tick(); tick();
    chk("store_stalled_state", {29'b0, state}, 32'd3);
    rstn = 1'b0;
    #1;
    chk("rst_mem_req_drop", {30'b0, mem_req, mem_we}, 32'd0);
    tick();
    chk("rst_mid_store_state", {29'b0, state}, 32'd0);
    chk("rst_mid_store_instret", instret, 32'd0);
    rstn = 1'b1;

    illegal_case(7'b1111111, 3'd0);
    illegal_case(7'b0000011, 3'd0);

    issue(7'b0110111, 3'd0, 1'b0, 0, 0);            // LUI after recovery
    chk("restart_instret", instret, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
